seq_alu: RTL
============

# seq_alu

Parametrised multi-cycle ALU, the successor to the single-cycle combinational ALU in the datapath. It executes the same 5-bit op-code set on WIDTH-bit signed operands. Logic, shift and add/sub ops finish in one cycle; multiply and divide run iteratively over WIDTH cycles. A start/done handshake lets the control unit stall while the unit is busy. The 2·WIDTH-bit result feeds the HI/LO registers.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- op_code  in  5  operation; sampled with start
- in_a  in  WIDTH  operand A; signed; sampled with start
- in_b  in  WIDTH  operand B; signed; sampled with start
- busy  out  1  high while an accepted op is in progress and not yet done
- done  out  1  one-cycle pulse when out becomes valid
- out  out  2·WIDTH  result, held until the next accepted start
- div_by_zero  out  1  set with done for DIV when in_b=0; otherwise 0
- illegal_op  out  1  set with done for an unlisted op-code; otherwise 0

## Operation
- Op-codes:
  - ADD 00011, SUB 00100, SHR 00101 (logical), SHL 00110, ROR 00111, ROL 01000
  - AND 01001, OR 01010, MUL 01110, DIV 01111, NEG 10000, NOT 10001
- Single-cycle ops:
  - out = {WIDTH zeros, r}.
  - ADD/SUB wrap modulo 2^WIDTH.
  - NEG = 0 − in_a. NOT = ~in_a.
  - Shift and rotate amount = in_b[log2(WIDTH)−1:0]; upper bits of in_b are ignored.
- MUL: out = full signed 2·WIDTH-bit product.
  - Algorithm: magnitude shift-add, one partial-product bit per cycle, then a sign-fix cycle.
- DIV: out = {remainder, quotient}.
  - Signed, truncating toward zero; the remainder takes the sign of in_a.
  - Algorithm: restoring division on magnitudes, one quotient bit per cycle, then a sign-fix cycle.
  - Most-negative / −1 gives quotient = most-negative (wraps) and remainder 0.
- DIV with in_b=0: no iteration.
  - out = {in_a, all ones}; div_by_zero=1.
  - Completes with single-cycle latency.
- Illegal op-code: out = 0; illegal_op=1; single-cycle latency.
- FSM states: IDLE, MUL_IT, DIV_IT, FIX, DONE.
  - IDLE: start with MUL → MUL_IT; start with DIV and in_b≠0 → DIV_IT; any other start → DONE.
  - MUL_IT/DIV_IT: an iteration counter counts WIDTH cycles, then → FIX.
  - FIX: applies the sign correction, writes out, then → DONE.
  - DONE: asserts done for one cycle, then → IDLE.
- Flags are cleared on every accepted start.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled with busy=0.
- Single-cycle ops, div-by-zero and illegal op-codes:
  - busy=1 in cycle 1 only; done=1 in cycle 1.
  - out is valid from cycle 1.
- MUL and non-zero DIV:
  - busy=1 in cycles 1 to WIDTH+2.
  - done=1 and out valid in cycle WIDTH+2 (cycle 34 at WIDTH=32).
- Back-to-back ops: a new start may be accepted in the cycle after done, when busy=0.
- start while busy=1 is ignored. In-flight operands, op and result are unaffected.
- out keeps its old value throughout an operation. It changes only in the done cycle.
- Reset values: reset_n=0 asynchronously forces the following, including mid-operation.
  - FSM = IDLE; busy = done = div_by_zero = illegal_op = 0; out = 0.
  - An aborted op never produces done.

## Test plan
- ADD, in_a=10, in_b=2, start in cycle 0 → done in cycle 1; out=64'h0000_0000_0000_000C. Then NOT on the same operands → out=64'h0000_0000_FFFF_FFF5.
- MUL, in_a=−7, in_b=3 → busy for cycles 1–34, done in cycle 34; out=64'hFFFF_FFFF_FFFF_FFEB. Also 32'h8000_0000 × 32'h8000_0000 → out=64'h4000_0000_0000_0000.
- DIV, in_a=−7, in_b=2 → done in cycle 34; out={32'hFFFF_FFFF, 32'hFFFF_FFFD}, i.e. remainder −1, quotient −3. Also 32'h8000_0000 / −1 → out={0, 32'h8000_0000}.
- DIV, in_a=5, in_b=0 → done in cycle 1; div_by_zero=1; out={32'h5, 32'hFFFF_FFFF}. Op-code 11111 → illegal_op=1, out=0.
- ROL, in_a=32'h8000_0001, in_b=32'h24 (amount 4) → out low word = 32'h0000_0018. SHR of the same operands → out low word = 32'h0800_0000.
- Start a MUL, pulse start again with ADD in cycle 5 → the ADD is ignored and the MUL result appears in cycle 34. Start a MUL, then assert reset_n=0 in cycle 10 → all outputs 0 immediately, no done. After release, ADD 1+1 → out=2 one cycle after start.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU with start/done handshake.
// Shift-add multiply and restoring divide over WIDTH cycles.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [4:0]         op_code,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               div_by_zero,
  output logic               illegal_op
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  typedef enum logic [2:0] {
    IDLE,
    MUL_IT,
    DIV_IT,
    FIX,
    DONE
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mq;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     dvs;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 is_div;

  logic [SW-1:0]        sh_amt;
  logic [2*WIDTH-1:0]   dbl;
  logic [WIDTH-1:0]     ror_r;
  logic [WIDTH-1:0]     rol_r;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_legal;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH:0]       div_diff;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // rotates come from the doubled operand, so no extra shifter
  assign sh_amt = in_b[SW-1:0];
  assign dbl    = {in_a, in_a};
  assign ror_r  = WIDTH'(dbl >> sh_amt);
  assign rol_r  = WIDTH'((dbl << sh_amt) >> WIDTH);

  assign a_neg  = in_a[WIDTH-1];
  assign b_neg  = in_b[WIDTH-1];
  assign a_mag  = a_neg ? -in_a : in_a;
  assign b_mag  = b_neg ? -in_b : in_b;

  // one restoring-division step on the magnitudes
  assign div_sh   = {rem, mq[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, dvs};

  assign quo_fix = neg_res ? -mq : mq;
  assign rem_fix = neg_rem ? -rem : rem;

  // single-cycle result and op-code legality
  always_comb begin
    sc_res   = '0;
    sc_legal = 1'b1;
    case (op_code)
      OP_ADD: sc_res = in_a + in_b;
      OP_SUB: sc_res = in_a - in_b;
      OP_SHR: sc_res = in_a >> sh_amt;
      OP_SHL: sc_res = in_a << sh_amt;
      OP_ROR: sc_res = ror_r;
      OP_ROL: sc_res = rol_r;
      OP_AND: sc_res = in_a & in_b;
      OP_OR:  sc_res = in_a | in_b;
      OP_NEG: sc_res = -in_a;
      OP_NOT: sc_res = ~in_a;
      OP_MUL,
      OP_DIV: sc_res = '0;
      default: sc_legal = 1'b0;
    endcase
  end

  // control FSM, iteration datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      out         <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mq          <= '0;
      rem         <= '0;
      dvs         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      is_div      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            cnt         <= '0;
            if (op_code == OP_MUL) begin
              state   <= MUL_IT;
              acc     <= '0;
              mcand   <= {{WIDTH{1'b0}}, a_mag};
              mq      <= b_mag;
              neg_res <= a_neg ^ b_neg;
              is_div  <= 1'b0;
            end else if (op_code == OP_DIV
                         && in_b != '0) begin
              state   <= DIV_IT;
              rem     <= '0;
              mq      <= a_mag;
              dvs     <= b_mag;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              is_div  <= 1'b1;
            end else if (op_code == OP_DIV) begin
              state       <= DONE;
              done        <= 1'b1;
              out         <= {in_a, {WIDTH{1'b1}}};
              div_by_zero <= 1'b1;
            end else begin
              state      <= DONE;
              done       <= 1'b1;
              out        <= {{WIDTH{1'b0}}, sc_res};
              illegal_op <= ~sc_legal;
            end
          end
        end
        MUL_IT: begin
          if (mq[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mq    <= mq >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        DIV_IT: begin
          rem <= div_diff[WIDTH] ? div_sh[WIDTH-1:0]
                                 : div_diff[WIDTH-1:0];
          mq  <= {mq[WIDTH-2:0], ~div_diff[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          done  <= 1'b1;
          if (is_div) out <= {rem_fix, quo_fix};
          else        out <= neg_res ? -acc : acc;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
